// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {IDLE, TAG, PASS, DRAIN} arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request after ptr, wrapping modulo N.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk the farthest candidate first so the nearest one after ptr wins.
  always_comb begin
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (req[j]) idx = IW'(j);
    end
  end

  assign found = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX byte stream among N_REQ sources.
// Optional tag byte before each packet: define UART_ARB_TAG_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 8
`ifdef UART_ARB_TAG_EN
  ,
  parameter logic [DW-1:0] TAG_BASE = 'h30
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DW-1:0]      req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_valid,
  output logic [DW-1:0]            tx_data,
  input  logic                     tx_ready,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int GW = idx_w(N_REQ);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic          tx_valid_q, tx_valid_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          busy_q, busy_d;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          own_valid, own_last, own_rdy;
  logic [DW-1:0] own_data;

  rr_pick #(.N(N_REQ), .IW(GW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own_valid = req_valid[grant_q];
  assign own_last  = req_last[grant_q];
  assign own_data  = req_data[int'(grant_q)*DW +: DW];
  // The output register can take a byte when empty or draining this cycle.
  assign own_rdy   = (state_q == PASS) && (!tx_valid_q || tx_ready);

  always_comb begin
    req_ready          = '0;
    req_ready[grant_q] = own_rdy;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          busy_d  = 1'b1;
`ifdef UART_ARB_TAG_EN
          tx_valid_d = 1'b1;
          tx_data_d  = TAG_BASE + DW'(pick_idx);
          state_d    = TAG;
`else
          state_d    = PASS;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = PASS;
        end
      end
`endif
      PASS: begin
        if (tx_ready) tx_valid_d = 1'b0;
        if (own_valid && own_rdy) begin
          tx_valid_d = 1'b1;
          tx_data_d  = own_data;
          if (own_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          rr_ptr_d   = grant_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= GW'(N_REQ - 1);
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a packet-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int GW = 2;
  localparam logic [7:0] TAG_BASE = 8'h30;

  typedef struct {logic [DW-1:0] data; logic last;} txn_t;
  typedef struct {logic [DW-1:0] data; int id;} exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             tx_valid;
  logic [DW-1:0]    tx_data;
  logic             tx_ready;
  logic [GW-1:0]    grant_id;
  logic             busy;

  uart_tx_arbiter #(.N_REQ(NR), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  txn_t src_q [NR][$];
  exp_t exp_q [$];
  int   model_ptr = NR - 1;
  logic mid [NR];
  int   stall_cnt [NR];
  int   stall_once [NR];
  int   rdy_mode = 0;
  bit   rnd_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NR; i++) n += src_q[i].size();
    return n;
  endfunction

  // Reference: whenever the path is free, the nearest requester after the last
  // owner that still has a packet sends that whole packet.
  task automatic predict();
    int pos [NR];
    int pick;
    txn_t t;
    for (int i = 0; i < NR; i++) pos[i] = 0;
    forever begin
      pick = -1;
      for (int k = 1; k <= NR; k++) begin
        int j;
        j = (model_ptr + k) % NR;
        if (pick < 0 && pos[j] < src_q[j].size()) pick = j;
      end
      if (pick < 0) break;
`ifdef UART_ARB_TAG_EN
      exp_q.push_back('{TAG_BASE + 8'(pick), pick});
`endif
      do begin
        t = src_q[pick][pos[pick]];
        pos[pick]++;
        exp_q.push_back('{t.data, pick});
      end while (!t.last);
      model_ptr = pick;
    end
  endtask

  task automatic add_pkt(input int r, input int len);
    for (int b = 0; b < len; b++)
      src_q[r].push_back('{8'($urandom_range(0, 255)), b == len - 1});
  endtask

  task automatic flush();
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      mid[i] = 1'b0;
      stall_cnt[i] = 0;
      stall_once[i] = 0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || pending() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("phase_timeout", n >= 3000, 0);
    if (n >= 3000) flush();
    repeat (3) @(negedge clk);
    chk("busy_after_phase", busy, 0);
  endtask

  // Requester drivers: only the owner may pause, and only inside a packet.
  initial begin
    logic [NR-1:0] fire;
    txn_t b;
    bit hold;
    req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < NR; i++) begin mid[i] = 0; stall_cnt[i] = 0; stall_once[i] = 0; end
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (fire[i] && src_q[i].size() > 0) begin
          b = src_q[i].pop_front();
          mid[i] = !b.last;
          if (!b.last && stall_once[i] > 0) begin
            stall_cnt[i] = stall_once[i];
            stall_once[i] = 0;
          end
        end
        hold = (stall_cnt[i] > 0) || (mid[i] && rnd_stall && $urandom_range(0, 3) == 0);
        if (stall_cnt[i] > 0) stall_cnt[i]--;
        if (src_q[i].size() > 0 && !hold) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = src_q[i][0].data;
          req_last[i] = src_q[i][0].last;
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*DW +: DW] = '0;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ($urandom_range(0, 2) != 0);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops on every accepted TX byte, plus protocol checks.
  initial begin
    bit prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic [NR-1:0] others;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", tx_valid, 1);
          chk("hold_data", tx_data, prev_data);
        end
        others = req_ready;
        others[grant_id] = 1'b0;
        if (busy) chk("ready_non_owner", others, 0);
        else chk("ready_idle", req_ready, 0);
        if (busy && tx_valid && !tx_ready) chk("ready_stall", req_ready, 0);
        if (busy && !tx_valid) chk("ready_owner", req_ready[grant_id], 1);
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte: got %0h expected none at %0t", tx_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", tx_data, e.data);
            chk("tx_owner", grant_id, e.id);
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single requester, back-to-back bytes and two-cycle latency.
    src_q[0].push_back('{8'h41, 1'b0});
    src_q[0].push_back('{8'h42, 1'b0});
    src_q[0].push_back('{8'h43, 1'b1});
    predict();
`ifndef UART_ARB_TAG_EN
    @(posedge clk); #2;
    chk("lat_c0_valid", tx_valid, 0);
    @(posedge clk); #2;
    chk("lat_c1_busy", busy, 1);
    chk("lat_c1_valid", tx_valid, 0);
    @(posedge clk); #2;
    chk("lat_c2_data", {tx_valid, tx_data}, {1'b1, 8'h41});
    @(posedge clk); #2;
    chk("lat_c3_data", {tx_valid, tx_data}, {1'b1, 8'h42});
    @(posedge clk); #2;
    chk("lat_c4_data", {tx_valid, tx_data}, {1'b1, 8'h43});
    @(posedge clk); #2;
    chk("lat_c5_done", {tx_valid, busy}, 0);
`endif
    wait_done();

    // Next search starts after requester 0.
    add_pkt(0, 2); add_pkt(1, 2);
    predict();
    wait_done();

    // Backpressure mid-packet.
    add_pkt(1, 4);
    predict();
    n = 0;
    while (!tx_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_start_timeout", n >= 50, 0);
    rdy_mode = 2;
    repeat (5) @(posedge clk);
    rdy_mode = 0;
    wait_done();

    // Lock: owner 2 stalls while 1 and 3 wait; 3 must go before 1.
    add_pkt(1, 2); add_pkt(2, 3); add_pkt(3, 1);
    stall_once[2] = 10;
    predict();
    n = 0;
    while (stall_cnt[2] == 0 && n < 50) begin @(negedge clk); n++; end
    chk("lock_stall_timeout", n >= 50, 0);
    repeat (5) begin
      @(negedge clk);
      chk("lock_ready1", req_ready[1], 0);
      chk("lock_owner", {busy, grant_id}, {1'b1, 2'd2});
    end
    wait_done();

    // Reset in the middle of a packet with a byte held in the output register.
    rdy_mode = 2;
    add_pkt(1, 3);
    predict();
    n = 0;
    while (!tx_valid && n < 50) begin @(negedge clk); n++; end
    chk("rst_mid_start_timeout", n >= 50, 0);
    chk("rst_mid_owner", grant_id, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx_valid", tx_valid, 0);
    chk("rst_mid_tx_data", tx_data, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_grant", grant_id, 0);
    chk("rst_mid_ready", req_ready, 0);
    flush();
    model_ptr = NR - 1;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    add_pkt(3, 2); add_pkt(0, 1);
    predict();
    wait_done();

    // All four requesters with single-byte packets.
    for (int i = 0; i < NR; i++) begin add_pkt(i, 1); add_pkt(i, 1); end
    predict();
    wait_done();

    // One-byte packet from requester 2 (preceded by its tag when tagging is built in).
    src_q[2].push_back('{8'h55, 1'b1});
    predict();
    wait_done();

    // Random traffic, backpressure and owner pauses.
    for (int p = 0; p < 30; p++) begin
      rdy_mode  = $urandom_range(0, 1);
      rnd_stall = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 1) == 1)
          for (int k = 0; k < int'($urandom_range(1, 2)); k++) add_pkt(i, $urandom_range(1, 4));
      predict();
      wait_done();
    end
    rdy_mode = 0;
    rnd_stall = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (valid/ready byte interface) between N_REQ requesters.
- Grants are round-robin and packet-locked: a granted requester owns the TX path until it hands over a byte flagged last.
- Sits in uart_test_top between the traffic sources and the uart_tx serializer.
- One registered output stage toward the UART, so tx_valid/tx_data come straight from flops.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DW, 8, data byte width
- TAG_BASE, 8'h30, base value of the tag byte (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester byte valid
- req_data  in  N_REQ*DW  per-requester byte; requester i occupies bits [i*DW +: DW]
- req_last  in  N_REQ  byte is the final byte of its packet
- req_ready  out  N_REQ  per-requester accept
- tx_valid  out  1  byte valid toward uart_tx
- tx_data  out  DW  byte toward uart_tx
- tx_ready  in  1  uart_tx accepts the byte
- grant_id  out  $clog2(N_REQ)  current or most recent grant owner
- busy  out  1  high while a packet is locked

Behaviour:
- Reset values (asynchronous, active-high):
  - State IDLE.
  - tx_valid=0, tx_data=0, req_ready=0, busy=0, grant_id=0.
  - Round-robin pointer rr_ptr=N_REQ-1, so requester 0 wins first.
- Reset asserted mid-packet: the in-flight byte in the output register is dropped, the lock is released, and no partial-state recovery is attempted.
- State IDLE:
  - If any req_valid is set, pick the first index searching rr_ptr+1, rr_ptr+2, … modulo N_REQ.
  - Register it into grant_id, set busy=1, go to PASS.
  - Arbitration takes one cycle; req_ready stays 0 in IDLE.
- State PASS:
  - req_ready[grant_id] = (!tx_valid || tx_ready). All other req_ready bits are 0.
  - On req_valid&&req_ready for the owner:
    - tx_data <= the owner's req_data slice; tx_valid <= 1.
    - If req_last is set, go to DRAIN.
  - On tx_ready with no new load: tx_valid <= 0.
  - Owner deasserting req_valid mid-packet: the lock holds indefinitely and no other requester is granted.
- State DRAIN:
  - Wait until the final byte is accepted (tx_valid&&tx_ready).
  - Then busy=0, rr_ptr<=grant_id, go to IDLE.
  - grant_id holds its value.
- Output stability: while tx_valid=1 and tx_ready=0, tx_valid and tx_data must not change.
- Latency and throughput:
  - req_valid seen in IDLE at cycle 0 → grant registered at edge 1 → first accept in cycle 1 → tx_valid high in cycle 2.
  - Full throughput of 1 byte/cycle when tx_ready is held high.
- Single-byte packet (req_last on the first byte) is legal.
- Minimum gap between packets: DRAIN→IDLE→grant costs 2 idle cycles on tx_valid.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- When defined, the state machine adds state TAG between IDLE and PASS:
  - TAG loads tx_data = TAG_BASE + grant_id, with tx_valid=1.
  - The requester is not readied until that tag byte is accepted (tx_ready).
  - Then the machine enters PASS.
  - Packet output becomes tag, payload…; latency to the first payload byte grows by 1 cycle plus the tag's ready stall.
- When undefined, the TAG state, TAG_BASE usage and related logic are absent; behaviour is exactly as above.

Decomposition:
- Package uart_arb_pkg:
  - typedef enum arb_state_t {IDLE, TAG, PASS, DRAIN}
  - localparam helpers for the grant-index width
- One sub-module, rr_pick: combinational round-robin priority finder.
  - Inputs: request vector, rr_ptr.
  - Outputs: found flag, index.
  - Reusable by other arbiters in the codebase.

Test Plan:
- Single requester: req 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_ready=1.
  - tx_data shows 0x41,0x42,0x43 on consecutive cycles starting 2 cycles after req_valid.
  - busy then drops; next grant search starts at index 1.
- All 4 requesters valid continuously with 1-byte packets.
  - Grant order is 0,1,2,3,0.
  - No requester is starved.
  - Verify each tx_data matches its source.
- Backpressure: tx_ready low for 5 cycles mid-packet.
  - tx_valid and tx_data stay constant; owner req_ready is 0.
  - No byte is lost or duplicated.
- Lock: req 2 owns the grant and stalls its req_valid for 10 cycles while req 1 is valid.
  - req_ready[1] stays 0.
  - After req 2's last byte, req 3 (if valid) is granted before req 1.
- Reset mid-packet: assert rst during PASS with tx_valid=1.
  - All outputs go to reset values immediately.
  - After release, requester 0 wins first.
- With UART_ARB_TAG_EN: req 2 sends byte 0x55 with last set.
  - tx_data sequence is 0x32, 0x55.
  - Without the macro, only 0x55 appears.
